// File: rtl/led_ctrl_pkg.sv
// Shared types and default timing constants for the LED mode controller.
// Mode encoding and the mode-advance order live here.
package led_ctrl_pkg;

  localparam int DEBOUNCE_LIMIT_DEF = 250000;
  localparam int TICK_LIMIT_DEF     = 12500000;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALL_ON = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    case (m)
      MODE_OFF:    r = MODE_ALL_ON;
      MODE_ALL_ON: r = MODE_BLINK;
      MODE_BLINK:  r = MODE_CHASE;
      default:     r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_mode_controller_if.sv
// Bundle between the switch filter bank and the mode core.
// sw = raw levels, ev = release events, led = LED drives.
interface led_mode_controller_if;
  logic [3:0] sw;
  logic [3:0] ev;
  logic [3:0] led;

  modport master (
    input  sw,
    output ev,
    input  led
  );

  modport slave (
    input  ev,
    output led
  );
endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchroniser, stability counter and registered
// release (1->0) event for one push switch.
module debounce_filter #(
  parameter int LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_rel
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(LIMIT - 1);

  logic [1:0]    sync_q;
  logic          stb_q, stb_d;
  logic          prev_q;
  logic          rel_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stb_d = stb_q;
    cnt_d = '0;
    if (sync_q[1] != stb_q) begin
      if (cnt_q == CMAX) begin
        stb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      stb_q  <= 1'b0;
      cnt_q  <= '0;
      prev_q <= 1'b0;
      rel_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_sw};
      stb_q  <= stb_d;
      cnt_q  <= cnt_d;
      prev_q <= stb_q;
      rel_q  <= prev_q & ~stb_q;
    end
  end

  assign o_rel = rel_q;

endmodule

// File: rtl/led_mode_controller_core.sv
// Mode FSM, direction/speed flags, step tick and LED pattern.
// LED drives are registered one clock behind the mode register.
module led_mode_controller_core
  import led_ctrl_pkg::*;
#(
  parameter int TICK_LIMIT = TICK_LIMIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  led_mode_controller_if.slave bus
);

  localparam int TW   = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
  localparam int FAST = (TICK_LIMIT / 4 > 0) ? TICK_LIMIT / 4 : 1;
  localparam logic [TW-1:0] SLOW_MAX = TW'(TICK_LIMIT - 1);
  localparam logic [TW-1:0] FAST_MAX = TW'(FAST - 1);

  mode_e         mode_q, mode_d;
  logic          dir_q, dir_d;
  logic          spd_q, spd_d;
  logic          phase_q, phase_d;
  logic [1:0]    pos_q, pos_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]    led_q, led_d;
  logic          chg, clr, tick;
  logic [TW-1:0] lim_max;

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q ^ bus.ev[1];
    spd_d   = spd_q ^ bus.ev[2];
    phase_d = phase_q;
    pos_d   = pos_q;
    led_d   = '0;

    // switch_4 beats switch_1 when both fire together
    if (bus.ev[3]) begin
      mode_d = MODE_OFF;
    end else if (bus.ev[0]) begin
      mode_d = next_mode(mode_q);
    end

    chg     = (mode_d != mode_q);
    clr     = chg | bus.ev[2];
    lim_max = spd_q ? FAST_MAX : SLOW_MAX;
    tick    = ~clr & (cnt_q == lim_max);
    cnt_d   = (clr | tick) ? '0 : cnt_q + TW'(1);

    if (chg) begin
      phase_d = 1'b1;
      pos_d   = dir_d ? 2'd3 : 2'd0;
    end else if (tick) begin
      phase_d = ~phase_q;
      pos_d   = dir_d ? pos_q - 2'd1 : pos_q + 2'd1;
    end

    unique case (mode_q)
      MODE_OFF:    led_d = 4'b0000;
      MODE_ALL_ON: led_d = 4'b1111;
      MODE_BLINK:  led_d = {4{phase_q}};
      MODE_CHASE:  led_d = 4'b0001 << pos_q;
      default:     led_d = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode_q  <= MODE_OFF;
      dir_q   <= 1'b0;
      spd_q   <= 1'b0;
      phase_q <= 1'b0;
      pos_q   <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      spd_q   <= spd_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign bus.led = led_q;

endmodule

// File: rtl/led_mode_controller.sv
// Top: four debounced switches feeding the LED mode core.
// LED bit 0 of the internal bundle is LED1.
module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEF,
  parameter int TICK_LIMIT     = TICK_LIMIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_switch_1,
  input  logic i_switch_2,
  input  logic i_switch_3,
  input  logic i_switch_4,
  output logic o_led_1,
  output logic o_led_2,
  output logic o_led_3,
  output logic o_led_4
);

  led_mode_controller_if bus ();

  logic [3:0] ev_w;

  assign bus.sw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

  for (genvar g = 0; g < 4; g++) begin : g_db
    debounce_filter #(
      .LIMIT (DEBOUNCE_LIMIT)
    ) u_db (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_sw  (bus.sw[g]),
      .o_rel (ev_w[g])
    );
  end

  assign bus.ev = ev_w;

  led_mode_controller_core #(
    .TICK_LIMIT (TICK_LIMIT)
  ) u_core (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  assign {o_led_4, o_led_3, o_led_2, o_led_1} = bus.led;

endmodule

// File: tb/tb_led_mode_controller.sv
// Directed bench for led_mode_controller with DEBOUNCE_LIMIT=4, TICK_LIMIT=8.
// LED vectors are written {LED1,LED2,LED3,LED4}.
module tb_led_mode_controller;
  import led_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic l1, l2, l3, l4;
  logic [3:0] ledv;
  int n_cmp = 0;
  int n_bad = 0;
  int ev_cnt = 0;

  led_mode_controller_if mon ();

  always #5 clk = ~clk;

  led_mode_controller #(
    .DEBOUNCE_LIMIT (4),
    .TICK_LIMIT     (8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_switch_1 (mon.sw[0]),
    .i_switch_2 (mon.sw[1]),
    .i_switch_3 (mon.sw[2]),
    .i_switch_4 (mon.sw[3]),
    .o_led_1    (l1),
    .o_led_2    (l2),
    .o_led_3    (l3),
    .o_led_4    (l4)
  );

  assign mon.led = {l4, l3, l2, l1};
  assign mon.ev  = dut.ev_w;
  assign ledv    = {l1, l2, l3, l4};

  always @(negedge clk) if (|mon.ev) ev_cnt++;

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // press for 8 clocks, release, return 8 edges after the release
  task automatic release_sw(input logic [3:0] m);
    mon.sw = m;
    tick_n(8);
    mon.sw = 4'b0000;
    tick_n(8);
  endtask

  initial begin
    rst    = 1'b1;
    mon.sw = 4'b0000;
    tick_n(3);
    chk("rst_led", 32'(ledv), 32'h0);
    chk("rst_mode", 32'(dut.u_core.mode_q), 32'(MODE_OFF));
    chk("rst_dir", 32'(dut.u_core.dir_q), 32'h0);
    chk("rst_spd", 32'(dut.u_core.spd_q), 32'h0);
    rst = 1'b0;
    tick_n(1);

    mon.sw = 4'b0001;
    tick_n(3);
    mon.sw = 4'b0000;
    tick_n(10);
    chk("glitch_led", 32'(ledv), 32'h0);
    chk("glitch_ev", 32'(ev_cnt), 32'h0);
    chk("glitch_mode", 32'(dut.u_core.mode_q), 32'(MODE_OFF));

    release_sw(4'b0001);
    chk("allon_e8", 32'(ledv), 32'h0);
    tick_n(1);
    chk("allon_e9", 32'(ledv), 32'hf);
    chk("one_event", 32'(ev_cnt), 32'h1);

    release_sw(4'b0001);
    release_sw(4'b0001);
    tick_n(1);
    chk("chase_e1", 32'(ledv), 32'b1000);
    tick_n(7);
    chk("chase_e8", 32'(ledv), 32'b1000);
    tick_n(1);
    chk("chase_s1", 32'(ledv), 32'b0100);
    tick_n(8);
    chk("chase_s2", 32'(ledv), 32'b0010);
    tick_n(8);
    chk("chase_s3", 32'(ledv), 32'b0001);
    tick_n(8);
    chk("chase_wrap", 32'(ledv), 32'b1000);

    release_sw(4'b0010);
    chk("dir_set", 32'(dut.u_core.dir_q), 32'h1);
    chk("rev_hold", 32'(ledv), 32'b0010);
    tick_n(7);
    chk("rev_e7", 32'(ledv), 32'b0010);
    tick_n(1);
    chk("rev_s1", 32'(ledv), 32'b0100);
    tick_n(8);
    chk("rev_s2", 32'(ledv), 32'b1000);
    tick_n(8);
    chk("rev_wrap", 32'(ledv), 32'b0001);

    release_sw(4'b0100);
    chk("spd_set", 32'(dut.u_core.spd_q), 32'h1);

    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    chk("mid_rst_led", 32'(ledv), 32'h0);
    chk("mid_rst_dir", 32'(dut.u_core.dir_q), 32'h0);
    chk("mid_rst_spd", 32'(dut.u_core.spd_q), 32'h0);
    chk("mid_rst_mode", 32'(dut.u_core.mode_q), 32'(MODE_OFF));

    release_sw(4'b0001);
    chk("re_allon_e8", 32'(ledv), 32'h0);
    tick_n(1);
    chk("re_allon_e9", 32'(ledv), 32'hf);

    release_sw(4'b0001);
    tick_n(1);
    chk("blink_entry", 32'(ledv), 32'hf);
    tick_n(7);
    chk("blink_e8", 32'(ledv), 32'hf);
    tick_n(1);
    chk("blink_slow", 32'(ledv), 32'h0);

    release_sw(4'b0100);
    chk("fast_spd", 32'(dut.u_core.spd_q), 32'h1);
    chk("fast_s0", 32'(ledv), 32'h0);
    tick_n(2);
    chk("fast_s2", 32'(ledv), 32'h0);
    tick_n(1);
    chk("fast_s3", 32'(ledv), 32'hf);
    tick_n(2);
    chk("fast_s5", 32'(ledv), 32'h0);
    tick_n(2);
    chk("fast_s7", 32'(ledv), 32'hf);

    release_sw(4'b1001);
    tick_n(1);
    chk("sw4_win_mode", 32'(dut.u_core.mode_q), 32'(MODE_OFF));
    chk("sw4_win_led", 32'(ledv), 32'h0);
    tick_n(3);
    chk("sw4_hold_led", 32'(ledv), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_mode_controller.md
LED_MODE_CONTROLLER -- requirements
Module: led_mode_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_LIMIT, default 250000, meaning the number of consecutive stable clocks required before a switch level is accepted.
REQ-002 SHALL have parameter TICK_LIMIT, default 12500000, meaning the clocks per pattern step in slow speed.
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports i_switch_1..i_switch_4, input, 1 bit each: raw asynchronous push-switch levels, 1 = pressed.
REQ-006 SHALL have ports o_led_1..o_led_4, output, 1 bit each: registered LED drives, 1 = lit.

Function
REQ-007 SHALL pass each switch through a 2-flop synchroniser, then a debounce filter:
- counter increments while the synchronised level differs from the stable level;
- counter clears to 0 when the levels match;
- when the counter equals DEBOUNCE_LIMIT-1 and the levels still differ, stable <= synchronised level and counter <= 0.
REQ-008 SHALL generate a one-clock registered release event when a stable level falls from 1 to 0; a press (0->1) generates no event.
REQ-009 SHALL hold a mode FSM with states MODE_OFF, MODE_ALL_ON, MODE_BLINK, MODE_CHASE; a switch_1 event advances OFF->ALL_ON->BLINK->CHASE->OFF, wrapping from CHASE to OFF.
REQ-010 SHALL force MODE_OFF on a switch_4 event; switch_4 wins over a switch_1 event in the same cycle.
REQ-011 SHALL toggle the chase direction flag (0 = forward 1->2->3->4->1, 1 = reverse 4->3->2->1->4) on a switch_2 event, in any mode.
REQ-012 SHALL toggle the speed flag on a switch_3 event; step limit = TICK_LIMIT when slow (0), TICK_LIMIT/4 when fast (1).
REQ-013 SHALL apply switch_2 and switch_3 events in the same cycle as each other and as any switch_1 or switch_4 event.
REQ-014 SHALL run the tick counter from 0 to limit-1, pulse tick for one clock at limit-1, then wrap to 0.
REQ-015 SHALL clear the tick counter on any mode change and on a speed change.
REQ-016 SHALL drive outputs per mode, registered one clock after the mode register:
- OFF: all 0.
- ALL_ON: all 1.
- BLINK: all equal to a phase bit that is set to 1 on entry and toggled on each tick.
- CHASE: one-hot, starting at LED1 (forward) or LED4 (reverse) on entry, stepping one LED per tick in the current direction.
REQ-017 SHALL take effect on the next tick after a direction change, continuing from the current chase position.
REQ-018 SHALL update o_led exactly DEBOUNCE_LIMIT+5 rising edges after a raw switch release, counting the first edge that samples the released level as edge 1.
REQ-019 SHALL ignore any pulse or glitch shorter than DEBOUNCE_LIMIT synchronised clocks: no event, no output change.

Reset
REQ-020 SHALL, while i_rst=1 at a clock edge, clear the following:
- synchronisers, stable levels and debounce counters to 0;
- events to 0, tick counter to 0;
- mode to MODE_OFF, direction to 0, speed to 0, phase to 0;
- all o_led to 0.
REQ-021 SHALL make reset asserted mid-operation (mid-debounce or mid-chase) take priority over all events in that cycle; behaviour after release is identical to power-up.

Structure
REQ-022 SHALL place the mode enum type and the default DEBOUNCE_LIMIT/TICK_LIMIT constants in shared package led_ctrl_pkg.
REQ-023 SHALL implement synchroniser, debounce filter and release-edge detect as sub-module debounce_filter, instantiated once per switch.

Verification
REQ-024 SHALL run all scenarios with DEBOUNCE_LIMIT=4 and TICK_LIMIT=8.
REQ-025 SHALL cover: after reset, release switch_1 once -> o_led_1..4 = 1111 exactly 9 edges after the release.
REQ-026 SHALL cover: switch_1 high for 3 clocks then low -> no event and o_led stays 0000.
REQ-027 SHALL cover: switch_1 released three times to reach CHASE -> o_led steps 1000, 0100, 0010, 0001, 1000, each step 8 clocks apart; after a switch_2 release the next step goes backwards.
REQ-028 SHALL cover: BLINK with a switch_3 release -> phase toggles every 2 clocks, counting from the speed change.
REQ-029 SHALL cover: switch_1 and switch_4 released on the same edge while in BLINK -> mode goes to MODE_OFF and o_led = 0000.
REQ-030 SHALL cover: i_rst pulsed for 1 clock mid-chase -> o_led = 0000 on the next edge; direction and speed read back as 0.
